risc16_dmem_resp: RTL and testbench

RISC16_DMEM_RESP -- requirements
Module: risc16_dmem_resp

---
 rtl/risc16_pkg.sv | 60 ++++++
 rtl/risc16_txq.sv | 69 ++++++
 rtl/risc16_dmem_resp.sv | 121 ++++++++++++
 tb/tb_risc16_dmem_resp.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared constants and helpers for the RISC16 data-memory
// responder. Holds the MMIO page and register addresses, the STATUS bit
// positions, the address-decode result type and a byte-lane merge helper.
package risc16_pkg;

    localparam logic [7:0]  MMIO_PAGE   = 8'hFF;
    localparam logic [15:0] ADDR_TXDATA = 16'hFF00;
    localparam logic [15:0] ADDR_STATUS = 16'hFF02;
    localparam logic [15:0] ADDR_CYCLE  = 16'hFF04;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;

    typedef enum logic [2:0] {
        SEL_RAM      = 3'd0,
        SEL_TXDATA   = 3'd1,
        SEL_STATUS   = 3'd2,
        SEL_CYCLE    = 3'd3,
        SEL_UNMAPPED = 3'd4
    } dsel_e;

    // Registers are decoded on the word address; the byte bit is not part of
    // the MMIO register identity.
    function automatic dsel_e decode_addr(input logic [15:0] addr);
        dsel_e sel;
        if (addr[15:8] != MMIO_PAGE) begin
            sel = SEL_RAM;
        end else begin
            case ({addr[15:1], 1'b0})
                ADDR_TXDATA: sel = SEL_TXDATA;
                ADDR_STATUS: sel = SEL_STATUS;
                ADDR_CYCLE:  sel = SEL_CYCLE;
                default:     sel = SEL_UNMAPPED;
            endcase
        end
        return sel;
    endfunction

    // Big-endian lane merge: we_hi owns bits [15:8], we_lo owns bits [7:0].
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                                input logic [15:0] new_word,
                                                input logic        we_hi,
                                                input logic        we_lo);
        logic [15:0] res;
        res = old_word;
        if (we_hi) begin
            res[15:8] = new_word[15:8];
        end else begin
            res[15:8] = old_word[15:8];
        end
        if (we_lo) begin
            res[7:0] = new_word[7:0];
        end else begin
            res[7:0] = old_word[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/risc16_txq.sv
// risc16_txq: outbound byte FIFO.
// Ports: clk, rst (sync active-low), push/push_data (enqueue), pop (dequeue),
//        head (oldest byte, 8'h00 when empty), full, empty.
// A push while full is accepted only if a pop happens in the same cycle.
module risc16_txq
    import risc16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int IW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IW:0] wr_q, wr_d;
    logic [IW:0] rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = rst && push && (!full || do_pop_s);
    assign head      = empty ? 8'h00 : mem_q[rd_q[IW-1:0]];

    // Next-state pointer arithmetic.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + (IW+1)'(1);
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + (IW+1)'(1);
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/risc16_dmem_resp.sv
// risc16_dmem_resp: data-memory responder for the RISC16 CPU data port.
// Ports: clk, rst (sync active-low); daddr/ddout/doe/dwe0/dwe1 from the CPU;
//        ddin read data (combinational, zero when doe=0);
//        tx_data/tx_valid/tx_ready outbound byte stream.
// Maps a word RAM everywhere except page 0xFF, which holds TXDATA, STATUS
// and a free-running CYCLE counter.
module risc16_dmem_resp
    import risc16_pkg::*;
#(
    parameter int RAM_AW    = 10,
    parameter int TXQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe0,
    input  logic        dwe1,
    output logic [15:0] ddin,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    dsel_e              sel_s;
    logic               any_we_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic [15:0]        ram_q [2**RAM_AW];
    logic               push_s;
    logic               pop_s;
    logic               q_full_s;
    logic               q_empty_s;
    logic               ovf_q, ovf_d;
    logic [15:0]        cycle_q, cycle_d;
    logic [15:0]        status_s;

    assign sel_s     = decode_addr(daddr);
    assign any_we_s  = dwe0 || dwe1;
    assign ram_idx_s = daddr[RAM_AW:1];
    assign push_s    = rst && (sel_s == SEL_TXDATA) && dwe1;
    assign pop_s     = tx_valid && tx_ready;
    assign tx_valid  = !q_empty_s;

    risc16_txq #(
        .DEPTH(TXQ_DEPTH)
    ) u_txq (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (ddout[7:0]),
        .pop       (pop_s),
        .head      (tx_data),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    // RAM byte-lane writes; contents survive reset but writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst && (sel_s == SEL_RAM) && any_we_s) begin
            ram_q[ram_idx_s] <= merge_bytes(ram_q[ram_idx_s], ddout, dwe0, dwe1);
        end
    end

    // Overflow flag: a dropped push outranks a simultaneous STATUS clear.
    always_comb begin
        ovf_d = ovf_q;
        if (push_s && q_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if ((sel_s == SEL_STATUS) && any_we_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Cycle counter: a write replaces the selected bytes instead of incrementing.
    always_comb begin
        cycle_d = cycle_q + 16'd1;
        if ((sel_s == SEL_CYCLE) && any_we_s) begin
            cycle_d = merge_bytes(cycle_q, ddout, dwe0, dwe1);
        end else begin
            cycle_d = cycle_q + 16'd1;
        end
    end

    // MMIO state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q   <= 1'b0;
            cycle_q <= 16'h0000;
        end else begin
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s                   = 16'h0000;
        status_s[STATUS_EMPTY_BIT] = q_empty_s;
        status_s[STATUS_FULL_BIT]  = q_full_s;
        status_s[STATUS_OVF_BIT]   = ovf_q;
    end

    // Same-cycle read mux; a concurrent write is seen only from the next cycle.
    always_comb begin
        ddin = 16'h0000;
        if (doe) begin
            case (sel_s)
                SEL_RAM:    ddin = ram_q[ram_idx_s];
                SEL_STATUS: ddin = status_s;
                SEL_CYCLE:  ddin = cycle_q;
                default:    ddin = 16'h0000;
            endcase
        end else begin
            ddin = 16'h0000;
        end
    end

endmodule

// File: tb/tb_risc16_dmem_resp.sv
// Self-checking bench for risc16_dmem_resp: directed scenarios plus
// randomized traffic compared against a queue/array reference model.
module tb_risc16_dmem_resp;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] daddr;
    logic [15:0] ddout;
    logic        doe;
    logic        dwe0;
    logic        dwe1;
    logic [15:0] ddin;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  q_m[$];
    logic        ovf_m;
    logic [15:0] cyc_m;
    logic [15:0] ram_m [int];

    always #5 clk = ~clk;

    risc16_dmem_resp #(.RAM_AW(10), .TXQ_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .daddr    (daddr),
        .ddout    (ddout),
        .doe      (doe),
        .dwe0     (dwe0),
        .dwe1     (dwe1),
        .ddin     (ddin),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    function automatic logic [15:0] status_m();
        return {13'b0, ovf_m, (q_m.size() == DEPTH), (q_m.size() == 0)};
    endfunction

    function automatic logic [15:0] exp_ddin();
        int k;
        if (!doe) return 16'h0000;
        if (daddr[15:8] == 8'hFF) begin
            if (daddr == 16'hFF02) return status_m();
            if (daddr == 16'hFF04) return cyc_m;
            return 16'h0000;
        end
        k = int'(daddr[10:1]);
        if (ram_m.exists(k)) return ram_m[k];
        return 16'h0000;
    endfunction

    task automatic idle();
        daddr = 16'h0000; ddout = 16'h0000; doe = 1'b0; dwe0 = 1'b0; dwe1 = 1'b0;
    endtask

    // Advance the model with the current inputs, then one clock.
    task automatic tick();
        bit          mmio, we, pop, push;
        int          k;
        logic [15:0] old;
        if (!rst) begin
            q_m.delete();
            ovf_m = 1'b0;
            cyc_m = 16'h0000;
        end else begin
            mmio = (daddr[15:8] == 8'hFF);
            we   = dwe0 || dwe1;
            pop  = (q_m.size() != 0) && tx_ready;
            push = mmio && (daddr == 16'hFF00) && dwe1;
            if (mmio && daddr == 16'hFF04 && we)
                cyc_m = {dwe0 ? ddout[15:8] : cyc_m[15:8], dwe1 ? ddout[7:0] : cyc_m[7:0]};
            else
                cyc_m = cyc_m + 16'd1;
            if (mmio && daddr == 16'hFF02 && we) ovf_m = 1'b0;
            if (push && q_m.size() == DEPTH && !pop) begin
                ovf_m = 1'b1;
            end else begin
                if (pop) void'(q_m.pop_front());
                if (push) q_m.push_back(ddout[7:0]);
            end
            if (!mmio && we) begin
                k   = int'(daddr[10:1]);
                old = ram_m.exists(k) ? ram_m[k] : 16'h0000;
                ram_m[k] = {dwe0 ? ddout[15:8] : old[15:8], dwe1 ? ddout[7:0] : old[7:0]};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        idle();
        daddr = 16'hFF00; ddout = {8'h00, b}; dwe1 = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0; tx_ready = 1'b0; idle();
        tick(); tick();
        #1;
        n_checks++; if (ddin !== 16'h0000) begin n_fail++; $display("FAIL reset_ddin actual=%h required=%h", ddin, 16'h0000); end
        rst = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid actual=%b required=0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data actual=%h required=00", tx_data); end
        doe = 1'b1; daddr = 16'hFF02; #1;
        n_checks++; if (ddin !== 16'h0001) begin n_fail++; $display("FAIL reset_status actual=%h required=0001", ddin); end
        daddr = 16'hFF04; #1;
        n_checks++; if (ddin !== 16'h0000) begin n_fail++; $display("FAIL reset_cycle actual=%h required=0000", ddin); end
        tick(); idle();
    endtask

    task automatic test_ram_word();
        idle(); daddr = 16'h0010; ddout = 16'hA55A; dwe0 = 1'b1; dwe1 = 1'b1;
        tick();
        idle(); doe = 1'b1; daddr = 16'h0011; #1;
        n_checks++; if (ddin !== 16'hA55A) begin n_fail++; $display("FAIL ram_word actual=%h required=A55A", ddin); end
        tick(); idle();
    endtask

    task automatic test_byte_lanes();
        idle(); daddr = 16'h0020; ddout = 16'h1234; dwe0 = 1'b1; dwe1 = 1'b1; tick();
        idle(); daddr = 16'h0020; ddout = 16'hFF00; dwe0 = 1'b1; tick();
        idle(); daddr = 16'h0020; doe = 1'b1; #1;
        n_checks++; if (ddin !== 16'hFF34) begin n_fail++; $display("FAIL lane_upper actual=%h required=FF34", ddin); end
        idle(); daddr = 16'h0020; ddout = 16'h0077; dwe1 = 1'b1; tick();
        idle(); daddr = 16'h0020; doe = 1'b1; #1;
        n_checks++; if (ddin !== 16'hFF77) begin n_fail++; $display("FAIL lane_lower actual=%h required=FF77", ddin); end
        tick(); idle();
    endtask

    task automatic test_ram_random();
        logic [15:0] e;
        int idx, hi;
        for (int i = 0; i < 8; i++) begin
            idle(); daddr = 16'(i << 1); ddout = 16'($urandom); dwe0 = 1'b1; dwe1 = 1'b1; tick();
        end
        for (int i = 0; i < 60; i++) begin
            idx   = $urandom_range(0, 7);
            hi    = $urandom_range(0, 30);
            daddr = 16'((hi << 11) | (idx << 1) | $urandom_range(0, 1));
            ddout = 16'($urandom);
            dwe0  = 1'($urandom_range(0, 1));
            dwe1  = 1'($urandom_range(0, 1));
            doe   = ($urandom_range(0, 3) != 0);
            #1;
            e = exp_ddin();
            n_checks++; if (ddin !== e) begin n_fail++; $display("FAIL ram_random addr=%h actual=%h required=%h", daddr, ddin, e); end
            tick();
        end
        idle();
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int b = 1; b <= 5; b++) push_byte(8'(b));
        doe = 1'b1; daddr = 16'hFF02; #1;
        n_checks++; if (ddin !== 16'h0006) begin n_fail++; $display("FAIL ovf_status actual=%h required=0006", ddin); end
        idle(); tx_ready = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            #1;
            n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid idx=%0d actual=%b required=1", b, tx_valid); end
            n_checks++; if (tx_data !== 8'(b)) begin n_fail++; $display("FAIL drain_data idx=%0d actual=%h required=%h", b, tx_data, 8'(b)); end
            tick();
        end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty actual=%b required=0", tx_valid); end
        idle(); daddr = 16'hFF02; dwe0 = 1'b1; tick();
        idle(); doe = 1'b1; daddr = 16'hFF02; #1;
        n_checks++; if (ddin !== 16'h0001) begin n_fail++; $display("FAIL ovf_clear actual=%h required=0001", ddin); end
        tick(); idle();
    endtask

    task automatic test_full_push_pop();
        tx_ready = 1'b0;
        for (int b = 0; b < 4; b++) push_byte(8'h10 + 8'(b));
        tx_ready = 1'b1;
        push_byte(8'h14);
        tx_ready = 1'b0;
        doe = 1'b1; daddr = 16'hFF02; #1;
        n_checks++; if (ddin !== 16'h0002) begin n_fail++; $display("FAIL full_pushpop_status actual=%h required=0002", ddin); end
        idle(); tx_ready = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            #1;
            n_checks++; if (tx_data !== (8'h10 + 8'(b)) || tx_valid !== 1'b1) begin
                n_fail++; $display("FAIL full_pushpop_order idx=%0d actual=%h/%b required=%h/1", b, tx_data, tx_valid, 8'h10 + 8'(b));
            end
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_cycle();
        logic [15:0] seq [4];
        logic [15:0] e;
        seq[0] = 16'hFFFE; seq[1] = 16'hFFFF; seq[2] = 16'h0000; seq[3] = 16'h0001;
        idle(); daddr = 16'hFF04; ddout = 16'hFFFE; dwe0 = 1'b1; dwe1 = 1'b1; tick();
        idle(); doe = 1'b1; daddr = 16'hFF04;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (ddin !== seq[i]) begin n_fail++; $display("FAIL cycle_wrap step=%0d actual=%h required=%h", i, ddin, seq[i]); end
            tick();
        end
        idle(); daddr = 16'hFF04; ddout = 16'h55AB; dwe1 = 1'b1; tick();
        idle(); doe = 1'b1; daddr = 16'hFF04; #1;
        e = exp_ddin();
        n_checks++; if (ddin !== e || ddin[7:0] !== 8'hAB) begin n_fail++; $display("FAIL cycle_lane actual=%h required=%h", ddin, e); end
        tick(); idle();
    endtask

    task automatic test_random_queue();
        int op;
        logic [15:0] e;
        for (int i = 0; i < 300; i++) begin
            idle();
            tx_ready = ($urandom_range(0, 9) < 3);
            op = $urandom_range(0, 9);
            if (op < 5) begin
                daddr = 16'hFF00; ddout = 16'($urandom); dwe1 = 1'b1;
                dwe0 = 1'($urandom_range(0, 1)); doe = 1'($urandom_range(0, 1));
            end else if (op == 5) begin
                daddr = 16'hFF02; dwe0 = 1'($urandom_range(0, 1)); dwe1 = !dwe0;
            end else if (op < 8) begin
                daddr = 16'hFF02; doe = 1'b1;
            end else if (op == 8) begin
                daddr = 16'hFF04; doe = 1'b1;
            end else begin
                daddr = ($urandom_range(0, 1) != 0) ? 16'hFF06 : 16'hFF80;
                ddout = 16'($urandom); doe = 1'b1;
                dwe0 = 1'($urandom_range(0, 1)); dwe1 = 1'($urandom_range(0, 1));
            end
            #1;
            e = exp_ddin();
            n_checks++; if (ddin !== e) begin n_fail++; $display("FAIL rq_ddin iter=%0d addr=%h actual=%h required=%h", i, daddr, ddin, e); end
            n_checks++; if (tx_valid !== (q_m.size() != 0)) begin n_fail++; $display("FAIL rq_valid iter=%0d actual=%b required=%b", i, tx_valid, q_m.size() != 0); end
            if (q_m.size() != 0) begin
                n_checks++; if (tx_data !== q_m[0]) begin n_fail++; $display("FAIL rq_data iter=%0d actual=%h required=%h", i, tx_data, q_m[0]); end
            end
            tick();
        end
        idle(); tx_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        tx_ready = 1'b0;
        for (int b = 0; b < 3; b++) push_byte(8'hC0 + 8'(b));
        idle(); daddr = 16'hFF04; ddout = 16'h0100; dwe0 = 1'b1; dwe1 = 1'b1; tick();
        idle(); doe = 1'b1; daddr = 16'hFF04; #1;
        n_checks++; if (ddin !== 16'h0100) begin n_fail++; $display("FAIL mid_cycle_load actual=%h required=0100", ddin); end
        idle(); rst = 1'b0; daddr = 16'h0010; ddout = 16'hDEAD; dwe0 = 1'b1; dwe1 = 1'b1;
        tick();
        rst = 1'b1; idle(); tx_ready = 1'b1; #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_tx_valid actual=%b required=0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data actual=%h required=00", tx_data); end
        doe = 1'b1; daddr = 16'hFF02; #1;
        n_checks++; if (ddin !== 16'h0001) begin n_fail++; $display("FAIL mid_status actual=%h required=0001", ddin); end
        daddr = 16'hFF04; #1;
        n_checks++; if (ddin !== 16'h0000) begin n_fail++; $display("FAIL mid_cycle actual=%h required=0000", ddin); end
        tick();
        doe = 1'b1; daddr = 16'hFF04; #1;
        n_checks++; if (ddin !== 16'h0001) begin n_fail++; $display("FAIL mid_cycle_run actual=%h required=0001", ddin); end
        daddr = 16'h0010; #1;
        n_checks++; if (ddin !== 16'hA55A) begin n_fail++; $display("FAIL mid_ram_keep actual=%h required=A55A", ddin); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_emit actual=%b required=0", tx_valid); end
        tick(); idle();
    endtask

    initial begin
        ovf_m = 1'b0; cyc_m = 16'h0000;
        test_reset();
        test_ram_word();
        test_byte_lanes();
        test_ram_random();
        test_overflow();
        test_full_push_pop();
        test_cycle();
        test_random_queue();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
